// File: rtl/adc_sample_streamer.sv
// rtl/adc_sample_streamer.sv - SPI-style master for a 16-bit serial ADC, one published sample per SAMPLE_PERIOD
// ADC_STREAMER_TESTPAT_EN adds test_pattern_i, which substitutes a 16-bit ramp for the shifted data at publish.
module adc_sample_streamer #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_i,
  input  logic        enable_i,
  input  logic        adc_miso_i,
`ifdef ADC_STREAMER_TESTPAT_EN
  input  logic        test_pattern_i,
`endif
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  output logic [15:0] sample_o,
  output logic        sample_valid_o,
  output logic        busy_o,
  output logic [31:0] sample_count_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(SAMPLE_PERIOD);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $fatal(1, "adc_sample_streamer: CLK_DIV must be >= 1");
  end
  if (SAMPLE_PERIOD < 33 * CLK_DIV + 2) begin : g_bad_sample_period
    $fatal(1, "adc_sample_streamer: SAMPLE_PERIOD must be >= 33*CLK_DIV+2");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    PUBLISH
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [15:0]   sample_q, sample_d;
  logic [31:0]   count_q, count_d;
  logic          phase_end;
`ifdef ADC_STREAMER_TESTPAT_EN
  logic [15:0]   ramp_q, ramp_d;
`endif

  assign phase_end = (div_q == DW'(CLK_DIV - 1));

  // Frame cadence is owned by pcnt alone, so the FSM never has to know the period.
  always_comb begin
    pcnt_d = '0;
    if (enable_i) begin
      pcnt_d = (pcnt_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : pcnt_q + PW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    valid_d  = 1'b0;
    sample_d = sample_q;
    count_d  = count_q;
`ifdef ADC_STREAMER_TESTPAT_EN
    ramp_d   = ramp_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable_i && (pcnt_q == '0)) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        div_d = phase_end ? '0 : div_q + DW'(1);
        if (phase_end) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
        end
      end
      SHIFT_HI: begin
        div_d = phase_end ? '0 : div_q + DW'(1);
        if (phase_end) begin
          shift_d = {shift_q[14:0], adc_miso_i};
          sclk_d  = 1'b0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        div_d = phase_end ? '0 : div_q + DW'(1);
        if (phase_end) begin
          if (bit_q == 4'd15) begin
            // Outputs are registered, so the publish strobe is set on the edge entering PUBLISH.
            state_d = PUBLISH;
            cs_n_d  = 1'b1;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
`ifdef ADC_STREAMER_TESTPAT_EN
            sample_d = test_pattern_i ? ramp_q : shift_q;
            ramp_d   = ramp_q + 16'd1;
`else
            sample_d = shift_q;
`endif
          end else begin
            bit_d   = bit_q + 4'd1;
            sclk_d  = 1'b1;
            state_d = SHIFT_HI;
          end
        end
      end
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = ~cs_n_d;
  end

  always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
    if (avl_reset_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pcnt_q   <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sample_q <= '0;
      count_q  <= '0;
`ifdef ADC_STREAMER_TESTPAT_EN
      ramp_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pcnt_q   <= pcnt_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      count_q  <= count_d;
`ifdef ADC_STREAMER_TESTPAT_EN
      ramp_q   <= ramp_d;
`endif
    end
  end

  assign adc_cs_n_o     = cs_n_q;
  assign adc_sclk_o     = sclk_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign sample_count_o = count_q;

endmodule

// File: tb/tb_adc_sample_streamer.sv
// tb/tb_adc_sample_streamer.sv - directed/random bench for adc_sample_streamer with behavioural ADC slaves
// dut_a uses the default timing, dut_b the minimum legal period; ADC_STREAMER_TESTPAT_EN enables the ramp steps.
module tb_adc_sample_streamer;
  localparam int CD  = 2;
  localparam int SP  = 100;
  localparam int CD1 = 1;
  localparam int SP1 = 35;
  localparam int NT  = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_a, miso_a, cs_a, sclk_a, valid_a, busy_a;
  logic [15:0] sample_a;
  logic [31:0] count_a;
  logic        en_b, miso_b, cs_b, sclk_b, valid_b, busy_b;
  logic [15:0] sample_b;
  logic [31:0] count_b;
`ifdef ADC_STREAMER_TESTPAT_EN
  logic        tp_a;
`endif

  adc_sample_streamer #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut_a (
    .avl_clk_i(clk), .avl_reset_i(rst), .enable_i(en_a), .adc_miso_i(miso_a),
`ifdef ADC_STREAMER_TESTPAT_EN
    .test_pattern_i(tp_a),
`endif
    .adc_cs_n_o(cs_a), .adc_sclk_o(sclk_a), .sample_o(sample_a),
    .sample_valid_o(valid_a), .busy_o(busy_a), .sample_count_o(count_a)
  );

  adc_sample_streamer #(.CLK_DIV(CD1), .SAMPLE_PERIOD(SP1)) dut_b (
    .avl_clk_i(clk), .avl_reset_i(rst), .enable_i(en_b), .adc_miso_i(miso_b),
`ifdef ADC_STREAMER_TESTPAT_EN
    .test_pattern_i(1'b0),
`endif
    .adc_cs_n_o(cs_b), .adc_sclk_o(sclk_b), .sample_o(sample_b),
    .sample_valid_o(valid_b), .busy_o(busy_b), .sample_count_o(count_b)
  );

  // ADC slaves: load a word when CS falls, advance one bit after each SCLK fall.
  logic [15:0] words_a[$], sent_a[$], pub_a[$];
  logic [15:0] words_b[$], sent_b[$], pub_b[$];
  int          vcyc_a[$];
  logic [15:0] w_a, w_b;
  int          idx_a, idx_b;

  always @(negedge cs_a) begin
    w_a = (words_a.size() > 0) ? words_a.pop_front() : 16'($urandom);
    sent_a.push_back(w_a);
    idx_a  = 15;
    miso_a = w_a[15];
  end
  always @(negedge sclk_a) begin
    #1;
    if (cs_a === 1'b0 && idx_a > 0) begin
      idx_a  = idx_a - 1;
      miso_a = w_a[idx_a];
    end
  end
  always @(negedge cs_b) begin
    w_b = (words_b.size() > 0) ? words_b.pop_front() : 16'($urandom);
    sent_b.push_back(w_b);
    idx_b  = 15;
    miso_b = w_b[15];
  end
  always @(negedge sclk_b) begin
    #1;
    if (cs_b === 1'b0 && idx_b > 0) begin
      idx_b  = idx_b - 1;
      miso_b = w_b[idx_b];
    end
  end

  logic tr_cs_a [0:NT-1];
  logic tr_sclk_a [0:NT-1];
  logic tr_cs_b [0:NT-1];
  int   busy_err = 0;
  int   dbl_err  = 0;
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  always @(negedge clk) begin
    if (cyc < NT) begin
      tr_cs_a[cyc]   = cs_a;
      tr_sclk_a[cyc] = sclk_a;
      tr_cs_b[cyc]   = cs_b;
    end
    if (busy_a !== ~cs_a || busy_b !== ~cs_b) busy_err++;
    if ((valid_a === 1'b1 && pv_a === 1'b1) || (valid_b === 1'b1 && pv_b === 1'b1)) dbl_err++;
    pv_a = valid_a;
    pv_b = valid_b;
    if (valid_a === 1'b1) begin
      pub_a.push_back(sample_a);
      vcyc_a.push_back(cyc);
    end
    if (valid_b === 1'b1) pub_b.push_back(sample_b);
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    #1;
    chk("valid_within_budget", 64'(got), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"},   64'(cs_a),    64'd1);
    chk({tag, "_sclk"},   64'(sclk_a),  64'd0);
    chk({tag, "_sample"}, 64'(sample_a), 64'd0);
    chk({tag, "_valid"},  64'(valid_a), 64'd0);
    chk({tag, "_busy"},   64'(busy_a),  64'd0);
    chk({tag, "_count"},  64'(count_a), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, s, v, n, m, t;
    en_a = 1'b0;
    en_b = 1'b0;
    miso_a = 1'b0;
    miso_b = 1'b0;
`ifdef ADC_STREAMER_TESTPAT_EN
    tp_a = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    // Basic frame followed by periodic cadence; two trailing frames use random ADC words.
    words_a = '{16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h1234};
    rst = 1'b0;
    repeat (2) @(negedge clk);
    c1 = cyc;
    en_a = 1'b1;
    en_b = 1'b1;
    s = c1 + 1;
    wait_valid(v);
    chk("first_valid_cycle", 64'(v), 64'(s + 33 * CD));
    chk("first_sample", 64'(sample_a), 64'h A5C3);
    chk("first_count", 64'(count_a), 64'd1);
    chk("cs_high_before_frame", 64'(tr_cs_a[s - 1]), 64'd1);
    n = 0;
    for (int r = 0; r < 33 * CD; r++) if (tr_cs_a[s + r] !== 1'b0) n++;
    chk("cs_low_66_cycles", 64'(n), 64'd0);
    chk("cs_high_at_publish", 64'(tr_cs_a[s + 33 * CD]), 64'd1);
    n = 0;
    m = 0;
    for (int r = 0; r <= 33 * CD; r++) begin
      if (tr_sclk_a[s + r] !== ((r >= CD) && (r < 33 * CD) && (((r / CD) % 2) == 1))) n++;
      if (r > 0 && tr_sclk_a[s + r] === 1'b1 && tr_sclk_a[s + r - 1] === 1'b0) m++;
    end
    chk("sclk_pattern_err", 64'(n), 64'd0);
    chk("sclk_pulses", 64'(m), 64'd16);

    for (int i = 1; i < 8; i++) wait_valid(v);
    chk("cadence_count", 64'(count_a), 64'd8);
    chk("cadence_npub", 64'(pub_a.size()), 64'd8);
    for (int i = 0; i < 7; i++) chk("cadence_gap", 64'(vcyc_a[i + 1] - vcyc_a[i]), 64'(SP));
    for (int i = 0; i < 8; i++) chk("cadence_value", 64'(pub_a[i]), 64'(sent_a[i]));

    // Disable in the middle of a frame.
    m = 0;
    while (cs_a !== 1'b0 && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("disable_frame_started", 64'(cs_a), 64'd0);
    s = cyc;
    repeat (20) @(negedge clk);
    en_a = 1'b0;
    wait_valid(v);
    chk("disable_valid_cycle", 64'(v), 64'(s + 33 * CD));
    chk("disable_value", 64'(pub_a[pub_a.size() - 1]), 64'(sent_a[sent_a.size() - 1]));
    chk("disable_count", 64'(count_a), 64'd9);
    repeat (300) @(negedge clk);
    #1;
    n = 0;
    for (t = s + 33 * CD + 1; t <= cyc; t++) if (tr_cs_a[t] === 1'b0) n++;
    chk("disable_no_new_frame", 64'(n), 64'd0);
    chk("disable_count_held", 64'(count_a), 64'd9);

    // Minimum-period instance has been running since c1.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      t = c1 + 1 + SP1 * i;
      if (!(tr_cs_b[t] === 1'b0 && tr_cs_b[t - 1] === 1'b1)) n++;
    end
    chk("minper_frame_starts", 64'(n), 64'd0);
    m = 0;
    for (t = c1 + 1; t < c1 + 1 + SP1 * 10; t++) if (tr_cs_b[t] === 1'b1) m++;
    chk("minper_cs_high_cycles", 64'(m), 64'd20);
    chk("minper_nvalid", 64'(pub_b.size() >= 10), 64'd1);
    n = 0;
    for (int i = 0; i < 10; i++) if (pub_b[i] !== sent_b[i]) n++;
    chk("minper_values", 64'(n), 64'd0);

    // Asynchronous reset between edges, 30 cycles into a frame.
    @(negedge clk);
    en_a = 1'b1;
    s = cyc + 1;
    repeat (31) @(negedge clk);
    chk("pre_reset_in_frame", 64'(cs_a), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    sent_a.delete();
    pub_a.delete();
    vcyc_a.delete();
    repeat (3) @(negedge clk);
    chk("reset_no_valid", 64'(pub_a.size()), 64'd0);
    rst = 1'b0;
    s = cyc + 1;
    wait_valid(v);
    chk("post_reset_valid_cycle", 64'(v), 64'(s + 33 * CD));
    chk("post_reset_value", 64'(sample_a), 64'(sent_a[0]));
    chk("post_reset_count", 64'(count_a), 64'd1);

`ifdef ADC_STREAMER_TESTPAT_EN
    en_a = 1'b0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    sent_a.delete();
    pub_a.delete();
    vcyc_a.delete();
    words_a = '{16'($urandom), 16'($urandom), 16'($urandom), 16'hBEEF};
    tp_a = 1'b1;
    rst  = 1'b0;
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(v);
      chk("testpat_ramp", 64'(sample_a), 64'(i));
    end
    tp_a = 1'b0;
    wait_valid(v);
    chk("testpat_off_adc_value", 64'(sample_a), 64'h BEEF);
`endif

    chk("busy_tracks_cs", 64'(busy_err), 64'd0);
    chk("valid_single_cycle", 64'(dbl_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
